game_flow_controller: RTL and testbench



---
 rtl/game_flow_controller.sv | 150 +++++++++++++++
 tb/tb_game_flow_controller.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// game_flow_controller: update-tick generation, game state machine and lives
// bookkeeping for the game top level. Motion and scoring ticks are only passed
// on while the player is alive (RUN state).
module game_flow_controller #(
  parameter int TICK_DIV    = 416667,
  parameter int FAST_DIV    = 104167,
  parameter int LIVES       = 3,
  parameter int START_TICKS = 60,
  parameter int CRASH_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       colision,
  output logic       upsig,
  output logic       upsig_fast,
  output logic       alive,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       game_over
);

  localparam int SW   = $clog2(TICK_DIV);
  localparam int FW   = $clog2(FAST_DIV);
  localparam int PMAX = (START_TICKS > CRASH_TICKS) ? START_TICKS : CRASH_TICKS;
  localparam int PW   = $clog2(PMAX) + 1;

  localparam logic [SW-1:0] SLOW_LAST  = SW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FAST_LAST  = FW'(FAST_DIV - 1);
  localparam logic [PW-1:0] START_LAST = PW'(START_TICKS - 1);
  localparam logic [PW-1:0] CRASH_LAST = PW'(CRASH_TICKS - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_CRASH = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic [SW-1:0] div_s;
  logic [FW-1:0] div_f;
  logic [PW-1:0] phase;
  logic          start_q;

  logic          tick_s;
  logic          tick_f;
  logic          start_re;
  logic [2:0]    next_state;
  logic [PW-1:0] next_phase;
  logic [1:0]    next_lives;

  assign tick_s   = (div_s == SLOW_LAST);
  assign tick_f   = (div_f == FAST_LAST);
  assign start_re = start & ~start_q;

  // Free-running tick dividers; never gated by the game state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_s <= '0;
      div_f <= '0;
    end else begin
      if (tick_s) div_s <= '0;
      else        div_s <= div_s + 1'b1;
      if (tick_f) div_f <= '0;
      else        div_f <= div_f + 1'b1;
    end
  end

  // Remember the previous start level so a held button yields one event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= start;
  end

  // Next-state, phase and lives decisions for the game flow
  always_comb begin
    next_state = state;
    next_phase = phase;
    next_lives = lives;
    case (state)
      S_IDLE, S_OVER: begin
        if (start_re) begin
          next_state = S_READY;
          next_lives = LIVES_INIT;
          next_phase = '0;
        end
      end
      S_READY: begin
        if (tick_s) begin
          if (phase == START_LAST) begin
            next_state = S_RUN;
            next_phase = '0;
          end else begin
            next_phase = phase + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (colision) begin
          next_state = S_CRASH;
          next_lives = (lives != 2'd0) ? lives - 1'b1 : lives;
          next_phase = '0;
        end
      end
      S_CRASH: begin
        if (tick_s) begin
          if (phase == CRASH_LAST) begin
            next_state = (lives == 2'd0) ? S_OVER : S_READY;
            next_phase = '0;
          end else begin
            next_phase = phase + 1'b1;
          end
        end
      end
      default: begin
        next_state = S_IDLE;
        next_phase = '0;
      end
    endcase
  end

  // Game state, phase counter and lives registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= '0;
      lives <= LIVES_INIT;
    end else begin
      state <= next_state;
      phase <= next_phase;
      lives <= next_lives;
    end
  end

  // Registered outputs; the collision cycle suppresses both update pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upsig      <= 1'b0;
      upsig_fast <= 1'b0;
      alive      <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      upsig      <= tick_s & (state == S_RUN) & ~colision;
      upsig_fast <= tick_f & (state == S_RUN) & ~colision;
      alive      <= (next_state == S_RUN);
      game_over  <= (next_state == S_OVER);
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: scenario tasks plus a random soak, all compared
// against a countdown-based behavioural model of the game flow.
module tb_game_flow_controller;

  localparam int TD = 10;
  localparam int FD = 4;
  localparam int NL = 2;
  localparam int ST = 2;
  localparam int CT = 3;

  localparam int M_IDLE  = 0;
  localparam int M_READY = 1;
  localparam int M_RUN   = 2;
  localparam int M_CRASH = 3;
  localparam int M_OVER  = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       colision;
  logic       upsig;
  logic       upsig_fast;
  logic       alive;
  logic [1:0] lives;
  logic [2:0] state;
  logic       game_over;

  int errors;
  int checks;

  // Behavioural model: cycle index since reset release, mode, lives and
  // the number of slow ticks still to wait in the current timed mode
  int m_k;
  int m_state;
  int m_lives;
  int m_left;
  bit m_prev_start;
  bit m_upsig;
  bit m_upsig_fast;
  bit m_alive;
  bit m_over;

  logic [8:0] dut_vec;
  assign dut_vec = {upsig, upsig_fast, alive, lives, state, game_over};

  game_flow_controller #(
    .TICK_DIV(TD), .FAST_DIV(FD), .LIVES(NL), .START_TICKS(ST), .CRASH_TICKS(CT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .colision(colision),
    .upsig(upsig),
    .upsig_fast(upsig_fast),
    .alive(alive),
    .lives(lives),
    .state(state),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] model_vec();
    return {m_upsig, m_upsig_fast, m_alive, 2'(m_lives), 3'(m_state), m_over};
  endfunction

  task automatic model_reset();
    m_k = 0;
    m_state = M_IDLE;
    m_lives = NL;
    m_left = 0;
    m_prev_start = 1'b0;
    m_upsig = 1'b0;
    m_upsig_fast = 1'b0;
    m_alive = 1'b0;
    m_over = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit col);
    bit ts;
    bit tf;
    bit sre;
    m_k++;
    ts = (m_k % TD == 0);
    tf = (m_k % FD == 0);
    sre = st && !m_prev_start;
    m_prev_start = st;
    m_upsig = ts && (m_state == M_RUN) && !col;
    m_upsig_fast = tf && (m_state == M_RUN) && !col;
    case (m_state)
      M_IDLE, M_OVER: if (sre) begin
        m_state = M_READY;
        m_lives = NL;
        m_left = ST;
      end
      M_READY: if (ts) begin
        m_left--;
        if (m_left == 0) m_state = M_RUN;
      end
      M_RUN: if (col) begin
        m_state = M_CRASH;
        m_lives--;
        m_left = CT;
      end
      default: if (ts) begin
        m_left--;
        if (m_left == 0) begin
          if (m_lives == 0) m_state = M_OVER;
          else begin
            m_state = M_READY;
            m_left = ST;
          end
        end
      end
    endcase
    m_alive = (m_state == M_RUN);
    m_over = (m_state == M_OVER);
  endtask

  task automatic cycle(input bit st, input bit col);
    start = st;
    colision = col;
    @(posedge clk);
    model_step(st, col);
    #1;
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1;
    start = 1'b0;
    colision = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({upsig, upsig_fast, alive, game_over} !== 4'b0 || state !== 3'd0 || lives !== 2'd2) begin
      errors++;
      $display("[TB] FAIL reset_hold: got out=%b state=%0d lives=%0d, want out=0000 state=0 lives=2",
               {upsig, upsig_fast, alive, game_over}, state, lives);
    end
    #1 reset = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL idle_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
      if (upsig || upsig_fast) pulses++;
    end
    checks++;
    if (state !== 3'd0 || alive !== 1'b0 || lives !== 2'd2 || pulses != 0) begin
      errors++;
      $display("[TB] FAIL idle_100: got state=%0d alive=%b lives=%0d pulses=%0d, want 0 0 2 0",
               state, alive, lives, pulses);
    end
  endtask

  task automatic test_start_held();
    int ready_entries;
    logic [2:0] prev;
    int last_s;
    int last_f;
    int n_s;
    int n_f;
    ready_entries = 0;
    prev = state;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL start_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
      if (state == 3'd1 && prev != 3'd1) ready_entries++;
      prev = state;
    end
    checks++;
    if (ready_entries != 1 || state !== 3'd2 || alive !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_once: got entries=%0d state=%0d alive=%b, want 1 2 1",
               ready_entries, state, alive);
    end
    last_s = -1;
    last_f = -1;
    n_s = 0;
    n_f = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL run_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
      if (upsig) begin
        if (last_s >= 0) begin
          checks++;
          if (i - last_s != TD) begin
            errors++;
            $display("[TB] FAIL upsig_period: got %0d want %0d", i - last_s, TD);
          end
        end
        last_s = i;
        n_s++;
      end
      if (upsig_fast) begin
        if (last_f >= 0) begin
          checks++;
          if (i - last_f != FD) begin
            errors++;
            $display("[TB] FAIL fast_period: got %0d want %0d", i - last_f, FD);
          end
        end
        last_f = i;
        n_f++;
      end
    end
    checks++;
    if (n_s != 60 / TD || n_f != 60 / FD) begin
      errors++;
      $display("[TB] FAIL pulse_count: got slow=%0d fast=%0d want %0d %0d", n_s, n_f, 60 / TD, 60 / FD);
    end
  endtask

  task automatic test_collision_on_tick();
    bit seen_ready;
    for (int n = 0; n < TD + 1 && ((m_k + 1) % TD != 0); n++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL pre_hit_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (upsig !== 1'b0 || alive !== 1'b0 || state !== 3'd3 || lives !== 2'd1) begin
      errors++;
      $display("[TB] FAIL hit_on_tick: got upsig=%b alive=%b state=%0d lives=%0d, want 0 0 3 1",
               upsig, alive, state, lives);
    end
    seen_ready = 1'b0;
    for (int n = 0; n < 200 && state !== 3'd2; n++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL recover_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
      if (state == 3'd1) seen_ready = 1'b1;
    end
    checks++;
    if (state !== 3'd2 || !seen_ready || alive !== 1'b1) begin
      errors++;
      $display("[TB] FAIL recover_run: got state=%0d ready_seen=%b alive=%b, want 2 1 1",
               state, seen_ready, alive);
    end
  endtask

  task automatic test_game_over();
    int w;
    w = $urandom_range(0, 15);
    for (int i = 0; i < w; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL pre_hit2_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (state !== 3'd3 || lives !== 2'd0) begin
      errors++;
      $display("[TB] FAIL second_hit: got state=%0d lives=%0d, want 3 0", state, lives);
    end
    for (int n = 0; n < 200 && state !== 3'd4; n++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL to_over_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
    end
    checks++;
    if (state !== 3'd4 || game_over !== 1'b1 || alive !== 1'b0) begin
      errors++;
      $display("[TB] FAIL over_entry: got state=%0d game_over=%b alive=%b, want 4 1 0",
               state, game_over, alive);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'($urandom % 2));
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL over_hold_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
    end
    checks++;
    if (state !== 3'd4 || lives !== 2'd0 || game_over !== 1'b1) begin
      errors++;
      $display("[TB] FAIL over_ignores_hit: got state=%0d lives=%0d game_over=%b, want 4 0 1",
               state, lives, game_over);
    end
    cycle(1'b1, 1'b0);
    checks++;
    if (state !== 3'd1 || lives !== 2'd2 || game_over !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart: got state=%0d lives=%0d game_over=%b, want 1 2 0",
               state, lives, game_over);
    end
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_colision_held();
    for (int n = 0; n < 200 && state !== 3'd2; n++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL held_pre_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (state !== 3'd3 || lives !== 2'd1) begin
      errors++;
      $display("[TB] FAIL held_first_hit: got state=%0d lives=%0d, want 3 1", state, lives);
    end
    for (int n = 0; n < 200 && state !== 3'd2; n++) begin
      cycle(1'b0, 1'b1);
      checks++;
      if (lives !== 2'd1 || dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL held_no_decrement k=%0d: got %b lives=%0d want %b lives=1",
                 m_k, dut_vec, lives, model_vec());
      end
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (state !== 3'd3 || lives !== 2'd0) begin
      errors++;
      $display("[TB] FAIL held_rehit: got state=%0d lives=%0d, want 3 0", state, lives);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("[TB] FAIL async_pre: got state=%0d want 3", state);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({upsig, upsig_fast, alive, game_over} !== 4'b0 || state !== 3'd0 || lives !== 2'd2) begin
      errors++;
      $display("[TB] FAIL async_reset: got out=%b state=%0d lives=%0d, want out=0000 state=0 lives=2",
               {upsig, upsig_fast, alive, game_over}, state, lives);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 45; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL post_reset_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_random_soak();
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom % 8 == 0), 1'($urandom % 12 == 0));
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL soak_trace k=%0d: got %b want %b", m_k, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    test_reset();
    test_start_held();
    test_collision_on_tick();
    test_game_over();
    test_colision_held();
    test_async_reset();
    test_random_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
